sa_deskew_writer: RTL and testbench

Output-side counterpart of the systolic-array input skew stage. The array emits results skewed: lane i of a row arrives i cycles after lane 0. This block removes that skew by delaying lane i by N-1-i cycles, then writes each realigned row to the output SRAM at an auto-incrementing address. A start/done job handshake frames each job.

---
 rtl/sa_pkg.sv | 17 +
 rtl/delay_line.sv | 44 ++++
 rtl/sa_deskew_writer.sv | 150 +++++++++++++++
 tb/tb_sa_deskew_writer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array output deskew writer.
// Holds the default lane and address widths, the lane data type and the
// job FSM state encoding used by sa_deskew_writer.
package sa_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 10;

  typedef logic [DEF_DW-1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } deskew_state_t;

endpackage

// File: rtl/delay_line.sv
// Fixed-length delay line used to realign one lane of array output.
// Ports:
//   clk   - clock, all flops update on the rising edge
//   rst_n - asynchronous active-low reset, clears every stage to 0
//   din   - lane data in
//   dout  - lane data delayed by LEN cycles (LEN=0 passes din straight through)
module delay_line #(
  parameter int LEN = 1,
  parameter int W   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    if (LEN == 0) begin : g_wire
      // With no stages the lane is a plain wire; clock and reset are
      // deliberately left unconnected to any logic here.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign dout = din;
    end else begin : g_flops
      logic [LEN-1:0][W-1:0] stage;

      // Shift the lane value one stage per clock; stage 0 takes the new
      // sample and the last stage feeds the output.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage <= '0;
        end else begin
          stage[0] <= din;
          for (int k = 1; k < LEN; k++) begin
            stage[k] <= stage[k-1];
          end
        end
      end

      assign dout = stage[LEN-1];
    end
  endgenerate

endmodule

// File: rtl/sa_deskew_writer.sv
// Output deskew and SRAM writer for a systolic array.
// Lane i of each result row arrives i cycles after lane 0; lane i is delayed
// by N-1-i cycles so that all lanes line up, then the realigned row is written
// to the output SRAM at an auto-incrementing address. A start/done handshake
// frames each job of num_rows rows.
// Ports:
//   clk, rst_n        - clock and asynchronous active-low reset
//   start             - job start pulse, only honoured in IDLE
//   base_addr         - first write address, latched on an accepted start
//   num_rows          - rows in the job, latched on an accepted start
//   in_valid          - marks lane 0 of a row; lane i follows i cycles later
//   data_in           - skewed lane data from the array
//   wen_n             - active-low SRAM write enable (registered)
//   waddr             - SRAM write address (registered)
//   data_out          - aligned row, zero whenever wen_n is high (registered)
//   busy              - high while the job is running
//   done              - one-cycle pulse at job end
module sa_deskew_writer
  import sa_pkg::*;
#(
  parameter int N  = 8,
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AW-1:0]        base_addr,
  input  logic [AW-1:0]        num_rows,
  input  logic                 in_valid,
  input  logic [N-1:0][DW-1:0] data_in,
  output logic                 wen_n,
  output logic [AW-1:0]        waddr,
  output logic [N-1:0][DW-1:0] data_out,
  output logic                 busy,
  output logic                 done
);

  localparam logic [AW-1:0] ONE = AW'(1);

  deskew_state_t        state;
  deskew_state_t        state_nxt;
  logic [AW-1:0]        rows_q;
  logic [AW-1:0]        acc_cnt;
  logic [AW-1:0]        wr_cnt;
  logic [N-2:0]         vld_sr;
  logic [N-1:0][DW-1:0] aligned;
  logic                 start_ok;
  logic                 accept;
  logic                 last_write;

  assign start_ok   = (state == IDLE) && start;
  assign accept     = (state == RUN) && in_valid && (acc_cnt < rows_q);
  assign last_write = (state == RUN) && !wen_n && (wr_cnt == rows_q - ONE);

  // Per-lane realignment: lane i waits N-1-i cycles so it meets lane N-1,
  // which arrives last and goes straight to the output register.
  for (genvar i = 0; i < N; i++) begin : g_lane
    delay_line #(
      .LEN (N - 1 - i),
      .W   (DW)
    ) u_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (data_in[i]),
      .dout  (aligned[i])
    );
  end

  // Job state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. An empty job skips RUN entirely; a running job ends
  // on the cycle its final write is presented to the SRAM.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt = (num_rows == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_write) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Job bookkeeping: the accepted-row count lets excess in_valid pulses be
  // dropped, the written-row count decides when the job is finished, and the
  // address advances (wrapping naturally) after every write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q  <= '0;
      acc_cnt <= '0;
      wr_cnt  <= '0;
      waddr   <= '0;
    end else if (start_ok) begin
      rows_q  <= num_rows;
      acc_cnt <= '0;
      wr_cnt  <= '0;
      waddr   <= base_addr;
    end else begin
      if (accept) begin
        acc_cnt <= acc_cnt + ONE;
      end
      if (!wen_n) begin
        wr_cnt <= wr_cnt + ONE;
        waddr  <= waddr + ONE;
      end
    end
  end

  // Valid tracking and output register. The valid of a row follows lane 0
  // through N-1 internal stages; the output register is the N-th stage, so
  // the write lands exactly N cycles after in_valid, with data gated to zero
  // on non-write cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr   <= '0;
      wen_n    <= 1'b1;
      data_out <= '0;
    end else begin
      vld_sr[0] <= accept;
      for (int k = 1; k < N - 1; k++) begin
        vld_sr[k] <= vld_sr[k-1];
      end
      wen_n    <= ~vld_sr[N-2];
      data_out <= vld_sr[N-2] ? aligned : '0;
    end
  end

endmodule

// File: tb/tb_sa_deskew_writer.sv
// Self-checking bench for sa_deskew_writer with N=4, DW=8, AW=10.
// A driver skews each row across the lanes and pushes the expected write
// (address, aligned data, cycle) into a scoreboard queue; a monitor pops and
// compares every write the DUT issues.
module tb_sa_deskew_writer;
  import sa_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 10;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [N*DW-1:0] data;
    int              cyc;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [AW-1:0]        base_addr;
  logic [AW-1:0]        num_rows;
  logic                 in_valid;
  logic [N-1:0][DW-1:0] data_in;
  logic                 wen_n;
  logic [AW-1:0]        waddr;
  logic [N-1:0][DW-1:0] data_out;
  logic                 busy;
  logic                 done;

  exp_t          q[$];
  exp_t          mon_e;
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  bit            mon_en = 0;
  bit            hv[N];
  int            hs[N];
  bit            m_run = 0;
  int            m_rows = 0;
  int            m_acc = 0;
  int            m_done_cyc = 0;
  logic [AW-1:0] m_base = '0;

  sa_deskew_writer #(
    .N  (N),
    .DW (DW),
    .AW (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .wen_n     (wen_n),
    .waddr     (waddr),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock and cycle index.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] lane_val(input int s, input int j);
    return DW'(s * 16 + j);
  endfunction

  // Drive one cycle: shift the skew history, present each lane of the rows
  // in flight, and record the expected write for any row the job accepts.
  task automatic applyStimulus(input bit v, input int seed, input bit st,
                               input logic [AW-1:0] b, input logic [AW-1:0] r);
    bit was_run;
    exp_t e;
    logic [N-1:0][DW-1:0] ed;
    @(posedge clk);
    #1;
    for (int j = N - 1; j > 0; j--) begin
      hv[j] = hv[j-1];
      hs[j] = hs[j-1];
    end
    hv[0] = v;
    hs[0] = seed;
    in_valid  = v;
    start     = st;
    base_addr = b;
    num_rows  = r;
    for (int j = 0; j < N; j++) begin
      data_in[j] = hv[j] ? lane_val(hs[j], j) : DW'($urandom);
    end
    was_run = m_run;
    if (v && was_run && (m_acc < m_rows)) begin
      for (int j = 0; j < N; j++) ed[j] = lane_val(seed, j);
      e.addr = m_base + AW'(m_acc);
      e.data = ed;
      e.cyc  = cyc + N;
      q.push_back(e);
      m_acc++;
      m_done_cyc = cyc + N + 1;
    end
    if (st && !was_run) begin
      m_run  = 1;
      m_base = b;
      m_rows = int'(r);
      m_acc  = 0;
      if (r == '0) m_done_cyc = cyc + 1;
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(0, 0, 0, '0, '0);
  endtask

  // Wait (bounded) for the done pulse and check its timing and width.
  task automatic waitDone();
    bit seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      applyStimulus(0, 0, 0, '0, '0);
      if (done) begin
        seen = 1;
        checkOutput("done_cycle", 64'(cyc), 64'(m_done_cyc));
        checkOutput("busy_at_done", 64'(busy), 64'd0);
      end
    end
    if (!seen) begin
      checkOutput("done_timeout", 64'd0, 64'd1);
    end else begin
      applyStimulus(0, 0, 0, '0, '0);
      checkOutput("done_width", 64'(done), 64'd0);
      checkOutput("scoreboard_empty", 64'(q.size()), 64'd0);
    end
    m_run = 0;
  endtask

  // Write monitor: every write must match the head of the scoreboard, and
  // data must be zero on every non-write cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!wen_n) begin
        if (q.size() == 0) begin
          checkOutput("unexpected_write", 64'(waddr), 64'h0);
          checks--;
          checkOutput("unexpected_write_flag", 64'd1, 64'd0);
        end else begin
          mon_e = q.pop_front();
          checkOutput("waddr", 64'(waddr), 64'(mon_e.addr));
          checkOutput("data_out", 64'(data_out), 64'(mon_e.data));
          checkOutput("write_cycle", 64'(cyc), 64'(mon_e.cyc));
        end
      end else begin
        checkOutput("idle_data_zero", 64'(data_out), 64'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    num_rows  = '0;
    in_valid  = 1'b0;
    data_in   = '0;
    for (int j = 0; j < N; j++) begin
      hv[j] = 0;
      hs[j] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_wen_n", 64'(wen_n), 64'd1);
    checkOutput("reset_waddr", 64'(waddr), 64'd0);
    checkOutput("reset_data_out", 64'(data_out), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    rst_n  = 1'b1;
    mon_en = 1;
    idleCycles(2);

    $display("[TB] single row job");
    applyStimulus(0, 0, 1, 10'h010, 10'd1);
    applyStimulus(1, 1, 0, '0, '0);
    checkOutput("busy_after_start", 64'(busy), 64'd1);
    waitDone();
    idleCycles(2);

    $display("[TB] back-to-back rows with one excess in_valid");
    applyStimulus(0, 0, 1, 10'h020, 10'd3);
    for (int r = 0; r < 4; r++) applyStimulus(1, r, 0, '0, '0);
    waitDone();
    idleCycles(2);

    $display("[TB] gapped rows with an ignored start during RUN");
    applyStimulus(0, 0, 1, 10'h040, 10'd3);
    applyStimulus(1, 0, 0, '0, '0);
    idleCycles(2);
    applyStimulus(1, 1, 0, '0, '0);
    applyStimulus(0, 0, 1, 10'h3AA, 10'd5);
    idleCycles(1);
    applyStimulus(1, 2, 0, '0, '0);
    waitDone();
    idleCycles(2);

    $display("[TB] in_valid in IDLE, then empty job");
    applyStimulus(1, 5, 0, '0, '0);
    idleCycles(N + 2);
    applyStimulus(0, 0, 1, 10'h080, 10'd0);
    waitDone();
    idleCycles(N + 2);

    $display("[TB] address wrap");
    applyStimulus(0, 0, 1, 10'h3FF, 10'd2);
    applyStimulus(1, 6, 0, '0, '0);
    applyStimulus(1, 7, 0, '0, '0);
    waitDone();
    idleCycles(2);

    $display("[TB] reset during a four-row job");
    applyStimulus(0, 0, 1, 10'h100, 10'd4);
    for (int r = 8; r < 12; r++) applyStimulus(1, r, 0, '0, '0);
    idleCycles(2);
    #1;
    rst_n = 1'b0;
    q.delete();
    m_run = 0;
    for (int j = 0; j < N; j++) hv[j] = 0;
    #1;
    checkOutput("midreset_wen_n", 64'(wen_n), 64'd1);
    checkOutput("midreset_waddr", 64'(waddr), 64'd0);
    checkOutput("midreset_data_out", 64'(data_out), 64'd0);
    checkOutput("midreset_busy", 64'(busy), 64'd0);
    checkOutput("midreset_done", 64'(done), 64'd0);
    idleCycles(2);
    rst_n = 1'b1;
    idleCycles(N + 2);
    checkOutput("post_reset_busy", 64'(busy), 64'd0);

    $display("[TB] clean job after reset");
    applyStimulus(0, 0, 1, 10'h200, 10'd2);
    applyStimulus(1, 12, 0, '0, '0);
    applyStimulus(1, 13, 0, '0, '0);
    waitDone();
    idleCycles(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
